// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: pipeline stall/flush control with a multi-cycle mul/div sequencer.
// Ports: clk, reset (sync, active-high); id_* ID source operands; ex_* EX load/mfc0,
// destination, mul/div op and branch mispredict; mem_exception; imem/dmem stalls.
// Outputs: per-stage stalls and flushes, md_busy (md stall is the winning cause),
// md_done (one-cycle release pulse).
module pipe_hazard_ctrl #(
  parameter int MUL_CYCLES = 3,
  parameter int DIV_CYCLES = 33
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] id_rs_addr,
  input  logic [4:0] id_rt_addr,
  input  logic       id_uses_rs,
  input  logic       id_uses_rt,
  input  logic       ex_mem_r,
  input  logic       ex_mfc0,
  input  logic [4:0] ex_rd_addr,
  input  logic [3:0] ex_md_op,
  input  logic       ex_bp_mispredict,
  input  logic       mem_exception,
  input  logic       imem_stall,
  input  logic       dmem_stall,
  output logic       pc_stall,
  output logic       ifid_stall,
  output logic       idex_stall,
  output logic       exmem_stall,
  output logic       ifid_flush,
  output logic       idex_flush,
  output logic       exmem_flush,
  output logic       memwb_flush,
  output logic       md_busy,
  output logic       md_done
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} md_state_t;
  md_state_t  state, state_nxt;
  logic [5:0] md_cnt, cnt_nxt;
  logic       redirect_pend, pend_nxt;
  logic       md_start, md_act, load_use, redirect;
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      md_cnt        <= '0;
      redirect_pend <= 1'b0;
    end else begin
      state         <= state_nxt;
      md_cnt        <= cnt_nxt;
      redirect_pend <= pend_nxt;
    end
  end
  always_comb begin
    md_start    = state == IDLE && ex_md_op >= 4'd1 && ex_md_op <= 4'd4;
    md_act      = md_start || state == BUSY;
    load_use    = (ex_mem_r || ex_mfc0) && ex_rd_addr != 5'd0 &&
                  ((id_uses_rs && ex_rd_addr == id_rs_addr) || (id_uses_rt && ex_rd_addr == id_rt_addr));
    // a mispredict that arrives under an imem stall is remembered until fetch resumes
    redirect    = ex_bp_mispredict || redirect_pend;
    pc_stall    = 1'b0;
    ifid_stall  = 1'b0;
    idex_stall  = 1'b0;
    exmem_stall = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    memwb_flush = 1'b0;
    md_busy     = 1'b0;
    md_done     = 1'b0;
    state_nxt   = state;
    cnt_nxt     = md_cnt;
    pend_nxt    = redirect_pend;
    if (reset || mem_exception) begin
      {ifid_flush, idex_flush, exmem_flush, memwb_flush} = 4'b1111;
      state_nxt = IDLE;
      cnt_nxt   = '0;
      pend_nxt  = 1'b0;
    end else if (dmem_stall) begin
      {pc_stall, ifid_stall, idex_stall, exmem_stall, memwb_flush} = 5'b11111;
    end else begin
      if (md_start) begin
        state_nxt = BUSY;
        cnt_nxt   = ex_md_op <= 4'd2 ? 6'(MUL_CYCLES - 1) : 6'(DIV_CYCLES - 1);
      end else if (state == BUSY) begin
        cnt_nxt   = md_cnt == 6'd0 ? 6'd0 : md_cnt - 6'd1;
        state_nxt = md_cnt <= 6'd1 ? DONE : BUSY;
      end else if (state == DONE) begin
        state_nxt = IDLE;
        md_done   = 1'b1;
      end
      if (md_act) begin
        {pc_stall, ifid_stall, idex_stall, exmem_flush, md_busy} = 5'b11111;
      end else if (load_use) begin
        {pc_stall, ifid_stall, idex_flush} = 3'b111;
      end else if (redirect && !imem_stall) begin
        ifid_flush = 1'b1;
        pend_nxt   = 1'b0;
      end else if (imem_stall) begin
        {pc_stall, ifid_stall, idex_flush} = 3'b111;
        pend_nxt = redirect;
      end
    end
  end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: table vectors plus multi-cycle sequences, checked through an expected-value queue.
module tb_pipe_hazard_ctrl;
  typedef struct packed {
    logic [4:0] rs, rt;
    logic       urs, urt, mr, mfc0;
    logic [4:0] rd;
    logic [3:0] op;
    logic       bp, exc, im, dm;
  } in_t;
  typedef struct {string name; in_t i; logic [9:0] e;} vec_t;
  typedef struct {string name; logic [9:0] e;} sb_t;
  localparam logic [9:0] E_NONE = 10'b0000_0000_00;
  localparam logic [9:0] E_EXC  = 10'b0000_1111_00;
  localparam logic [9:0] E_DMEM = 10'b1111_0001_00;
  localparam logic [9:0] E_MD   = 10'b1110_0010_10;
  localparam logic [9:0] E_LU   = 10'b1100_0100_00;
  localparam logic [9:0] E_IM   = 10'b1100_0100_00;
  localparam logic [9:0] E_BP   = 10'b0000_1000_00;
  localparam logic [9:0] E_DONE = 10'b0000_0000_01;
  logic clk = 1'b0, reset = 1'b1;
  logic [4:0] id_rs_addr, id_rt_addr, ex_rd_addr;
  logic id_uses_rs, id_uses_rt, ex_mem_r, ex_mfc0, ex_bp_mispredict, mem_exception, imem_stall, dmem_stall;
  logic [3:0] ex_md_op;
  logic pc_stall, ifid_stall, idex_stall, exmem_stall, ifid_flush, idex_flush, exmem_flush, memwb_flush, md_busy, md_done;
  logic [9:0] got;
  sb_t q[$];
  vec_t vecs[17];
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  assign got = {pc_stall, ifid_stall, idex_stall, exmem_stall, ifid_flush, idex_flush, exmem_flush, memwb_flush, md_busy, md_done};
  pipe_hazard_ctrl dut (
    .clk(clk), .reset(reset), .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .ex_mem_r(ex_mem_r), .ex_mfc0(ex_mfc0),
    .ex_rd_addr(ex_rd_addr), .ex_md_op(ex_md_op), .ex_bp_mispredict(ex_bp_mispredict),
    .mem_exception(mem_exception), .imem_stall(imem_stall), .dmem_stall(dmem_stall),
    .pc_stall(pc_stall), .ifid_stall(ifid_stall), .idex_stall(idex_stall), .exmem_stall(exmem_stall),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_flush(exmem_flush), .memwb_flush(memwb_flush),
    .md_busy(md_busy), .md_done(md_done)
  );
  task automatic cyc(input string n, input in_t i, input logic [9:0] e);
    sb_t s;
    {id_rs_addr, id_rt_addr, id_uses_rs, id_uses_rt, ex_mem_r, ex_mfc0, ex_rd_addr, ex_md_op,
     ex_bp_mispredict, mem_exception, imem_stall, dmem_stall} = i;
    q.push_back('{n, e});
    @(negedge clk);
    s = q.pop_front();
    checks++;
    if (got !== s.e) begin
      failures++;
      $display("FAIL %s got=%b exp=%b", s.name, got, s.e);
    end
    @(posedge clk);
    #1;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "timeout");
  end
  initial begin
    in_t v;
    vecs[0]  = '{"idle",       '{5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 4'd0,  1'b0, 1'b0, 1'b0, 1'b0}, E_NONE};
    vecs[1]  = '{"lu_rs",      '{5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd5, 4'd0,  1'b0, 1'b0, 1'b0, 1'b0}, E_LU};
    vecs[2]  = '{"lu_rt",      '{5'd0, 5'd7, 1'b0, 1'b1, 1'b1, 1'b0, 5'd7, 4'd0,  1'b0, 1'b0, 1'b0, 1'b0}, E_LU};
    vecs[3]  = '{"lu_rd0",     '{5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 4'd0,  1'b0, 1'b0, 1'b0, 1'b0}, E_NONE};
    vecs[4]  = '{"lu_nouse",   '{5'd5, 5'd5, 1'b0, 1'b0, 1'b1, 1'b0, 5'd5, 4'd0,  1'b0, 1'b0, 1'b0, 1'b0}, E_NONE};
    vecs[5]  = '{"lu_mfc0",    '{5'd9, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd9, 4'd0,  1'b0, 1'b0, 1'b0, 1'b0}, E_LU};
    vecs[6]  = '{"lu_miss",    '{5'd5, 5'd4, 1'b1, 1'b1, 1'b1, 1'b0, 5'd6, 4'd0,  1'b0, 1'b0, 1'b0, 1'b0}, E_NONE};
    vecs[7]  = '{"bp",         '{5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 4'd0,  1'b1, 1'b0, 1'b0, 1'b0}, E_BP};
    vecs[8]  = '{"imem",       '{5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 4'd0,  1'b0, 1'b0, 1'b1, 1'b0}, E_IM};
    vecs[9]  = '{"op5",        '{5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 4'd5,  1'b0, 1'b0, 1'b0, 1'b0}, E_NONE};
    vecs[10] = '{"op15",       '{5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 4'd15, 1'b0, 1'b0, 1'b0, 1'b0}, E_NONE};
    vecs[11] = '{"dmem",       '{5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 4'd0,  1'b0, 1'b0, 1'b0, 1'b1}, E_DMEM};
    vecs[12] = '{"dmem_op1",   '{5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 4'd1,  1'b0, 1'b0, 1'b0, 1'b1}, E_DMEM};
    vecs[13] = '{"exc_all",    '{5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd5, 4'd1,  1'b1, 1'b1, 1'b1, 1'b1}, E_EXC};
    vecs[14] = '{"dmem_vs_lu", '{5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd5, 4'd0,  1'b0, 1'b0, 1'b0, 1'b1}, E_DMEM};
    vecs[15] = '{"lu_vs_bp",   '{5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd5, 4'd0,  1'b1, 1'b0, 1'b0, 1'b0}, E_LU};
    vecs[16] = '{"idle_after", '{5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 4'd0,  1'b0, 1'b0, 1'b0, 1'b0}, E_NONE};
    v = '0;
    @(posedge clk);
    #1;
    cyc("reset", v, E_EXC);
    reset = 1'b0;
    for (int k = 0; k < 17; k++) cyc(vecs[k].name, vecs[k].i, vecs[k].e);
    v = '0; v.rs = 5'd5; v.urs = 1'b1; v.mr = 1'b1; v.rd = 5'd5;
    cyc("lu_seq_stall", v, E_LU);
    v.mr = 1'b0;
    cyc("lu_seq_release", v, E_NONE);
    v = '0; v.op = 4'd1;
    for (int k = 0; k < 3; k++) cyc("mult_stall", v, E_MD);
    cyc("mult_done", v, E_DONE);
    v.op = 4'd0;
    cyc("mult_after", v, E_NONE);
    v.op = 4'd3;
    for (int k = 0; k < 33; k++) cyc("div_stall", v, E_MD);
    cyc("div_done", v, E_DONE);
    v.op = 4'd0;
    cyc("div_after", v, E_NONE);
    v.op = 4'd4;
    for (int k = 0; k < 10; k++) cyc("divd_stall_a", v, E_MD);
    v.dm = 1'b1;
    for (int k = 0; k < 5; k++) cyc("divd_dmem", v, E_DMEM);
    v.dm = 1'b0;
    for (int k = 0; k < 23; k++) cyc("divd_stall_b", v, E_MD);
    cyc("divd_done", v, E_DONE);
    v.op = 4'd0;
    cyc("divd_after", v, E_NONE);
    v.op = 4'd3;
    for (int k = 0; k < 9; k++) cyc("dive_stall", v, E_MD);
    v.exc = 1'b1;
    cyc("dive_exc", v, E_EXC);
    v = '0;
    for (int k = 0; k < 3; k++) cyc("dive_abort_idle", v, E_NONE);
    v.bp = 1'b1; v.im = 1'b1;
    cyc("bp_imem_1", v, E_IM);
    v.bp = 1'b0;
    cyc("bp_imem_2", v, E_IM);
    cyc("bp_imem_3", v, E_IM);
    v.im = 1'b0;
    cyc("bp_redirect", v, E_BP);
    cyc("bp_cleared", v, E_NONE);
    v.op = 4'd3;
    for (int k = 0; k < 5; k++) cyc("divr_stall", v, E_MD);
    reset = 1'b1;
    cyc("divr_reset_1", v, E_EXC);
    cyc("divr_reset_2", v, E_EXC);
    reset = 1'b0;
    v.op = 4'd0;
    cyc("divr_idle", v, E_NONE);
    v.op = 4'd1;
    for (int k = 0; k < 3; k++) cyc("mulr_stall", v, E_MD);
    cyc("mulr_done", v, E_DONE);
    v.op = 4'd0;
    cyc("mulr_after", v, E_NONE);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter MUL_CYCLES, default 3, meaning total EX stall cycles for mult/multu.
REQ-002 SHALL have parameter DIV_CYCLES, default 33, meaning total EX stall cycles for div/divu; legal range 2..64.
REQ-003 SHALL have ports:
- clk  in  1  clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- id_rs_addr, id_rt_addr  in  5 each  source registers of the instruction in ID.
- id_uses_rs, id_uses_rt  in  1 each  ID instruction reads rs/rt.
- ex_mem_r, ex_mfc0  in  1 each  EX instruction is a load / mfc0.
- ex_rd_addr  in  5  EX destination register.
- ex_md_op  in  4  EX multiply/divide op: 1,2 = mult/multu; 3,4 = div/divu; other values start nothing.
- ex_bp_mispredict  in  1  EX branch resolved against prediction.
- mem_exception  in  1  exception taken in MEM.
- imem_stall, dmem_stall  in  1 each  fetch / data access not complete.
- pc_stall, ifid_stall, idex_stall, exmem_stall  out  1 each  hold the PC / stage register.
- ifid_flush, idex_flush, exmem_flush, memwb_flush  out  1 each  load a bubble into the stage register.
- md_busy  out  1  multiply/divide sequence stalling EX.
- md_done  out  1  one-cycle pulse: result ready, EX instruction released.

Function
REQ-004 SHALL hold state as follows: md FSM (IDLE, BUSY, DONE), 6-bit down-counter md_cnt, and 1-bit redirect_pend.
REQ-005 SHALL compute all stall/flush outputs combinationally from inputs and state, with a single winning cause per cycle, highest priority first (REQ-006..REQ-011).
REQ-006 mem_exception SHALL assert ifid_flush, idex_flush, exmem_flush and memwb_flush, force every stall to 0, and move the FSM to IDLE with md_cnt=0 and redirect_pend=0 at the next edge (abort mid-operation).
REQ-007 dmem_stall SHALL assert pc_stall, ifid_stall, idex_stall, exmem_stall and memwb_flush; all other flushes are 0; FSM and md_cnt are frozen.
REQ-008 md stall SHALL be active when (FSM=IDLE and ex_md_op in 1..4) or FSM=BUSY; it SHALL assert pc_stall, ifid_stall, idex_stall and exmem_flush, and md_busy=1.
REQ-009 Load-use SHALL be detected when (ex_mem_r or ex_mfc0), ex_rd_addr!=0, and ex_rd_addr equals id_rs_addr with id_uses_rs, or equals id_rt_addr with id_uses_rt; it SHALL assert pc_stall, ifid_stall and idex_flush.
REQ-010 ex_bp_mispredict SHALL assert ifid_flush; the delay slot in ID advances normally.
REQ-011 imem_stall SHALL assert pc_stall, ifid_stall and idex_flush.
REQ-012 If ex_bp_mispredict is high while imem_stall is high, redirect_pend SHALL set; in the first cycle imem_stall is low, ifid_flush=1 and redirect_pend clears.
REQ-013 When no cause is active, all stall and flush outputs SHALL be 0.
REQ-014 md FSM transitions, gated by the absence of dmem_stall and mem_exception:
- IDLE and start: to BUSY; md_cnt = MUL_CYCLES-1 or DIV_CYCLES-1.
- BUSY: decrement md_cnt; at md_cnt=1, go to DONE.
- DONE: md_done=1, no md stall, no start; to IDLE next edge.
REQ-015 Total stall for mult SHALL be exactly MUL_CYCLES cycles, and for div exactly DIV_CYCLES cycles, from the first cycle ex_md_op is seen, excluding dmem_stall cycles.
REQ-016 ex_md_op values 0 and 5..15 SHALL never start the FSM.

Reset
REQ-017 While reset is high, all stalls, md_busy and md_done SHALL be 0, and all four flushes SHALL be 1.
REQ-018 At the reset edge, FSM SHALL go to IDLE, md_cnt to 0 and redirect_pend to 0, overriding any in-flight operation.

Verification
REQ-019 Load lw to r5 in EX, ID reads rs=5 -> exactly 1 cycle of pc_stall=ifid_stall=idex_flush=1; with rd=0 -> no stall.
REQ-020 ex_md_op=3 held in EX -> md_busy=1 for 33 cycles with exmem_flush=1, then md_done=1 for 1 cycle, stalls 0; op=1 -> 3 stall cycles.
REQ-021 div start, dmem_stall high for 5 cycles mid-BUSY -> md_cnt frozen, total md stall = 33 cycles and md_done delayed by 5 cycles.
REQ-022 mem_exception during div cycle 10 -> all four flushes=1 and stalls=0 that cycle; next cycle FSM=IDLE, md_busy=0, no md_done.
REQ-023 Mispredict with imem_stall high for 3 cycles -> ifid_flush=0 while stalled, then 1 in the first cycle imem_stall is low, then 0.
REQ-024 Reset asserted during div BUSY -> outputs per REQ-017; after release, md_busy=0 and a new mult gives 3 stall cycles.
